div_unit: RTL



---
 rtl/div_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative RV32M divider for DIV, DIVU, REM and REMU. It uses a radix-2
//   restoring algorithm and produces one quotient bit per clock, so a normal
//   operation takes 32 iterations. Division by zero and signed overflow are
//   resolved when the request is accepted and complete in a single cycle.
//   Requests and responses both use valid/ready handshakes. A request is taken
//   only while the unit is IDLE, so operations never overlap.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  unit can accept a request (FSM in IDLE)
//   div_op     in   2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   div_in1    in   dividend (sampled only on the accept edge)
//   div_in2    in   divisor  (sampled only on the accept edge)
//   kill       in   synchronous abort; overrides every other transition
//   rsp_valid  out  result valid (FSM in DONE)
//   rsp_ready  in   consumer takes the result
//   div_out    out  registered quotient or remainder
//   busy       out  high while in CALC or DONE
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_in1,
  input  logic [XLEN-1:0] div_in2,
  input  logic            kill,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] div_out,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negation with XLEN-bit wrap, applied conditionally.
  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Control state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [XLEN-1:0]    div_out_q, div_out_d;

  // Datapath state (written only on accept / iteration, never reset)
  logic [1:0]         op_q,   op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [XLEN-1:0]    dvsr_q, dvsr_d;
  logic [XLEN-1:0]    rem_q,  rem_d;
  logic [XLEN-1:0]    quo_q,  quo_d;

  // ---------------------------------------------------------------------------
  // Accept-edge operand conditioning
  // ---------------------------------------------------------------------------
  logic                   accept;
  logic                   signed_op;
  logic signed [XLEN-1:0] in1_s, in2_s;
  logic                   neg1, neg2;
  logic [XLEN-1:0]        mag1, mag2;
  logic                   div_zero, sgn_ovf, special;
  logic [XLEN-1:0]        special_res;

  assign req_ready = (state_q == IDLE);
  // kill in IDLE blocks the accept even with req_valid high.
  assign accept    = req_valid & req_ready & ~kill;
  assign signed_op = ~div_op[0];

  assign in1_s = div_in1;
  assign in2_s = div_in2;
  assign neg1  = signed_op && (in1_s < 0);
  assign neg2  = signed_op && (in2_s < 0);
  assign mag1  = negate_if(div_in1, neg1);
  assign mag2  = negate_if(div_in2, neg2);

  assign div_zero = (div_in2 == '0);
  assign sgn_ovf  = signed_op && (div_in1 == INT_MIN) && (div_in2 == ALL_ONE);
  assign special  = div_zero | sgn_ovf;

  // Divide-by-zero has priority, though the two cases cannot coincide.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = div_op[1] ? div_in1 : ALL_ONE;
    end else if (sgn_ovf) begin
      special_res = div_op[1] ? '0 : INT_MIN;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   part_rem;
  logic            trial_ok;
  logic [XLEN-1:0] rem_it, quo_it;
  logic [XLEN-1:0] q_fin, r_fin, fin_res;
  logic            last_it;

  // The partial remainder is below the divisor before the shift, so after
  // the shift it needs XLEN+1 bits. When the trial subtraction succeeds, the
  // difference is again below the divisor and fits in XLEN bits, so a wrapped
  // XLEN-bit subtraction gives the exact result.
  assign part_rem = {rem_q, quo_q[XLEN-1]};
  assign trial_ok = (part_rem >= {1'b0, dvsr_q});
  assign rem_it   = trial_ok ? (part_rem[XLEN-1:0] - dvsr_q) : part_rem[XLEN-1:0];
  assign quo_it   = {quo_q[XLEN-2:0], trial_ok};
  assign last_it  = (cnt_q == LAST_IT);

  // Sign fix-up uses this iteration's values, so the result lands in div_out
  // on the same edge as the last iteration.
  assign q_fin   = negate_if(quo_it, qneg_q);
  assign r_fin   = negate_if(rem_it, rneg_q);
  assign fin_res = op_q[1] ? r_fin : q_fin;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_out_d = div_out_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dvsr_d    = dvsr_q;
    rem_d     = rem_q;
    quo_d     = quo_q;

    if (kill) begin
      // Discard the in-flight operation. div_out keeps its last value.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_d   = div_op;
            qneg_d = neg1 ^ neg2;
            rneg_d = neg1;
            dvsr_d = mag2;
            rem_d  = '0;
            quo_d  = mag1;
            cnt_d  = '0;
            if (special) begin
              state_d   = DONE;
              div_out_d = special_res;
            end else begin
              state_d   = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_it;
          quo_d = quo_it;
          cnt_d = cnt_q + 1'b1;   // wraps 31 -> 0 on the final iteration
          if (last_it) begin
            state_d   = DONE;
            div_out_d = fin_res;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dvsr_q <= dvsr_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign div_out   = div_out_q;

endmodule
